// File: rtl/jtag_tap_pkg.sv
// Shared types and default constants for the clk-domain JTAG TAP responder.
// Holds the 16-state TAP encoding and the TAP next-state function.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_IDLE       = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_SEL_BYPASS = 2'd0,
    DR_SEL_IDCODE = 2'd1,
    DR_SEL_USER   = 2'd2
  } dr_sel_e;

  localparam int unsigned IR_LEN_DEF    = 5;
  localparam int unsigned DR_LEN        = 32;
  localparam logic [31:0] IDCODE_DEF    = 32'h1000_0001;
  localparam logic [4:0]  OP_IDCODE_DEF = 5'h01;
  localparam logic [4:0]  OP_USER_DEF   = 5'h10;
  localparam logic [4:0]  OP_BYPASS_DEF = 5'h1F;

  function automatic tap_state_e tap_next(input tap_state_e cur, input logic tms);
    tap_state_e nxt;
    case (cur)
      TAP_RESET:      nxt = tms ? TAP_RESET     : TAP_IDLE;
      TAP_IDLE:       nxt = tms ? TAP_SELECT_DR : TAP_IDLE;
      TAP_SELECT_DR:  nxt = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: nxt = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   nxt = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   nxt = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   nxt = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   nxt = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  nxt = tms ? TAP_SELECT_DR : TAP_IDLE;
      TAP_SELECT_IR:  nxt = tms ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: nxt = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   nxt = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   nxt = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   nxt = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   nxt = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  nxt = tms ? TAP_SELECT_DR : TAP_IDLE;
      default:        nxt = TAP_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tck_sync.sv
// Brings TCK/TMS/TDI into the clk domain through 2-flop synchronizers and
// turns synchronized TCK into single-clk rise/fall event strobes.
module jtag_tck_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic tms_o,
  output logic tdi_o
);

  // tck_pipe: [0] metastable stage, [1] synchronized, [2] delayed copy for edge detect
  logic [2:0] tck_pipe_q, tck_pipe_d;
  logic [1:0] tms_pipe_q, tms_pipe_d;
  logic [1:0] tdi_pipe_q, tdi_pipe_d;

  // next value of every synchronizer stage
  always_comb begin
    tck_pipe_d = {tck_pipe_q[1:0], tck_i};
    tms_pipe_d = {tms_pipe_q[0], tms_i};
    tdi_pipe_d = {tdi_pipe_q[0], tdi_i};
  end

  // synchronizer flops, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_pipe_q <= 3'b000;
      tms_pipe_q <= 2'b00;
      tdi_pipe_q <= 2'b00;
    end else begin
      tck_pipe_q <= tck_pipe_d;
      tms_pipe_q <= tms_pipe_d;
      tdi_pipe_q <= tdi_pipe_d;
    end
  end

  assign tck_rise_o = tck_pipe_q[1] & ~tck_pipe_q[2];
  assign tck_fall_o = ~tck_pipe_q[1] & tck_pipe_q[2];
  assign tms_o      = tms_pipe_q[1];
  assign tdi_o      = tdi_pipe_q[1];

endmodule

// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP controller run entirely in the clk domain from oversampled
// TCK, with IDCODE, USER and BYPASS data registers.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int unsigned         IR_LEN     = IR_LEN_DEF,
  parameter logic [31:0]         IDCODE_VAL = IDCODE_DEF,
  parameter logic [IR_LEN-1:0]   OP_IDCODE  = OP_IDCODE_DEF,
  parameter logic [IR_LEN-1:0]   OP_USER    = OP_USER_DEF,
  parameter logic [IR_LEN-1:0]   OP_BYPASS  = OP_BYPASS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jtag_TCK,
  input  logic        jtag_TMS,
  input  logic        jtag_TDI,
  output logic        jtag_TDO_data,
  output logic        jtag_TDO_driven,
  input  logic [31:0] user_capture_data,
  output logic [31:0] user_update_data,
  output logic        user_update_valid,
  output logic [3:0]  tap_state
);

  localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-2){1'b0}}, 2'b01};

  logic tck_rise_s, tck_fall_s, tms_s, tdi_s;
  dr_sel_e dr_sel_s;

  tap_state_e          state_q, state_d;
  logic [IR_LEN-1:0]   ir_q, ir_d;
  logic [IR_LEN-1:0]   ir_shift_q, ir_shift_d;
  logic [DR_LEN-1:0]   dr_shift_q, dr_shift_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_drv_q, tdo_drv_d;
  logic [31:0]         upd_data_q, upd_data_d;
  logic                upd_valid_q, upd_valid_d;

  jtag_tck_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .tck_i      (jtag_TCK),
    .tms_i      (jtag_TMS),
    .tdi_i      (jtag_TDI),
    .tck_rise_o (tck_rise_s),
    .tck_fall_o (tck_fall_s),
    .tms_o      (tms_s),
    .tdi_o      (tdi_s)
  );

  // data register selected by the current instruction; unknown opcodes act as BYPASS
  always_comb begin
    if (ir_q == OP_BYPASS) begin
      dr_sel_s = DR_SEL_BYPASS;
    end else if (ir_q == OP_IDCODE) begin
      dr_sel_s = DR_SEL_IDCODE;
    end else if (ir_q == OP_USER) begin
      dr_sel_s = DR_SEL_USER;
    end else begin
      dr_sel_s = DR_SEL_BYPASS;
    end
  end

  // TAP next state and register actions: capture/shift on rise, TDO and update on fall
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ir_shift_d  = ir_shift_q;
    dr_shift_d  = dr_shift_q;
    bypass_d    = bypass_q;
    tdo_d       = tdo_q;
    tdo_drv_d   = tdo_drv_q;
    upd_data_d  = upd_data_q;
    upd_valid_d = 1'b0;

    if (tck_rise_s) begin
      state_d = tap_next(state_q, tms_s);
      case (state_q)
        TAP_CAPTURE_IR: ir_shift_d = IR_CAPTURE;
        TAP_SHIFT_IR:   ir_shift_d = {tdi_s, ir_shift_q[IR_LEN-1:1]};
        TAP_CAPTURE_DR: begin
          case (dr_sel_s)
            DR_SEL_IDCODE: dr_shift_d = IDCODE_VAL | 32'h0000_0001;
            DR_SEL_USER:   dr_shift_d = user_capture_data;
            default:       bypass_d   = 1'b0;
          endcase
        end
        TAP_SHIFT_DR: begin
          if (dr_sel_s == DR_SEL_BYPASS) begin
            bypass_d = tdi_s;
          end else begin
            dr_shift_d = {tdi_s, dr_shift_q[DR_LEN-1:1]};
          end
        end
        default: begin
          ir_shift_d = ir_shift_q;
        end
      endcase
      if (state_d == TAP_RESET) begin
        ir_d = OP_IDCODE;
      end else begin
        ir_d = ir_q;
      end
    end else if (tck_fall_s) begin
      tdo_d     = 1'b0;
      tdo_drv_d = 1'b0;
      case (state_q)
        TAP_SHIFT_IR: begin
          tdo_d     = ir_shift_q[0];
          tdo_drv_d = 1'b1;
        end
        TAP_SHIFT_DR: begin
          tdo_d     = (dr_sel_s == DR_SEL_BYPASS) ? bypass_q : dr_shift_q[0];
          tdo_drv_d = 1'b1;
        end
        TAP_UPDATE_IR: ir_d = ir_shift_q;
        TAP_UPDATE_DR: begin
          if (dr_sel_s == DR_SEL_USER) begin
            upd_data_d  = dr_shift_q;
            upd_valid_d = 1'b1;
          end else begin
            upd_data_d = upd_data_q;
          end
        end
        default: begin
          tdo_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // all TAP state and output flops; reset abandons any shift in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TAP_RESET;
      ir_q        <= OP_IDCODE;
      ir_shift_q  <= '0;
      dr_shift_q  <= '0;
      bypass_q    <= 1'b0;
      tdo_q       <= 1'b0;
      tdo_drv_q   <= 1'b0;
      upd_data_q  <= 32'h0000_0000;
      upd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_shift_q  <= ir_shift_d;
      dr_shift_q  <= dr_shift_d;
      bypass_q    <= bypass_d;
      tdo_q       <= tdo_d;
      tdo_drv_q   <= tdo_drv_d;
      upd_data_q  <= upd_data_d;
      upd_valid_q <= upd_valid_d;
    end
  end

  assign jtag_TDO_data     = tdo_q;
  assign jtag_TDO_driven   = tdo_drv_q;
  assign user_update_data  = upd_data_q;
  assign user_update_valid = upd_valid_q;
  assign tap_state         = state_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: TCK is bit-banged in whole clk
// periods and TDO is sampled at the end of each TCK low phase.
module tb_jtag_tap_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        jtag_TCK = 1'b0;
  logic        jtag_TMS = 1'b1;
  logic        jtag_TDI = 1'b0;
  logic        jtag_TDO_data;
  logic        jtag_TDO_driven;
  logic [31:0] user_capture_data = 32'h0000_0000;
  logic [31:0] user_update_data;
  logic        user_update_valid;
  logic [3:0]  tap_state;

  int   checks = 0;
  int   errors = 0;
  int   half_clks = 4;
  int   pulse_cnt = 0;
  logic tdo_lo = 1'b0;
  logic drv_lo = 1'b0;

  jtag_tap_responder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .jtag_TCK          (jtag_TCK),
    .jtag_TMS          (jtag_TMS),
    .jtag_TDI          (jtag_TDI),
    .jtag_TDO_data     (jtag_TDO_data),
    .jtag_TDO_driven   (jtag_TDO_driven),
    .user_capture_data (user_capture_data),
    .user_update_data  (user_update_data),
    .user_update_valid (user_update_valid),
    .tap_state         (tap_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (user_update_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic tck_step(input logic tms, input logic tdi);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    jtag_TCK = 1'b0;
    #(half_clks * 10);
    tdo_lo = jtag_TDO_data;
    drv_lo = jtag_TDO_driven;
    jtag_TCK = 1'b1;
    #(half_clks * 10);
  endtask

  task automatic do_reset();
    jtag_TCK = 1'b0;
    jtag_TMS = 1'b1;
    jtag_TDI = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic goto_idle();
    for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
  endtask

  // Idle -> Shift-IR, shift 5 bits, Update-IR -> Idle
  task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
    tck_step(1'b1, 1'b0);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tck_step(i == 4, din[i]);
      dout[i] = tdo_lo;
    end
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
  endtask

  // Idle -> Shift-DR, shift n bits, Update-DR -> Idle
  task automatic scan_dr(input logic [63:0] din, input int n, output logic [63:0] dout,
                         output logic drv_all, output logic drv_after);
    dout    = 64'h0;
    drv_all = 1'b1;
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tck_step(i == n - 1, din[i]);
      dout[i] = tdo_lo;
      drv_all = drv_all & drv_lo;
    end
    tck_step(1'b1, 1'b0);
    drv_after = drv_lo;
    tck_step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL rst_state got %h exp %h", tap_state, 4'hF); end
    checks++; if (jtag_TDO_data !== 1'b0) begin errors++; $display("FAIL rst_tdo got %b exp 0", jtag_TDO_data); end
    checks++; if (jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL rst_drv got %b exp 0", jtag_TDO_driven); end
    checks++; if (user_update_data !== 32'h0) begin errors++; $display("FAIL rst_upd got %h exp 0", user_update_data); end
    checks++; if (user_update_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", user_update_valid); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_idcode();
    logic [63:0] dout;
    logic drv_all, drv_after;
    goto_idle();
    checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL idle_state got %h exp %h", tap_state, 4'hC); end
    checks++; if (drv_lo !== 1'b0) begin errors++; $display("FAIL tlr_drv got %b exp 0", drv_lo); end
    scan_dr(64'h0, 32, dout, drv_all, drv_after);
    checks++; if (dout[31:0] !== 32'h1000_0001) begin errors++; $display("FAIL idcode got %h exp %h", dout[31:0], 32'h1000_0001); end
    checks++; if (drv_all !== 1'b1) begin errors++; $display("FAIL idcode_drv_shift got %b exp 1", drv_all); end
    checks++; if (drv_after !== 1'b0) begin errors++; $display("FAIL idcode_drv_exit got %b exp 0", drv_after); end
    checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL idcode_end_state got %h exp %h", tap_state, 4'hC); end
  endtask

  task automatic test_tdo_timing();
    logic changed;
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    jtag_TMS = 1'b0;
    jtag_TCK = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    jtag_TCK = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tap_state !== 4'h6) begin errors++; $display("FAIL rise_lat_early got %h exp %h", tap_state, 4'h6); end
    @(posedge clk);
    #1;
    checks++; if (tap_state !== 4'h2) begin errors++; $display("FAIL rise_lat_3rd got %h exp %h", tap_state, 4'h2); end
    checks++; if (jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL drv_on_rise got %b exp 0", jtag_TDO_driven); end
    @(negedge clk);
    jtag_TCK = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL fall_lat_early got %b exp 0", jtag_TDO_driven); end
    @(posedge clk);
    #1;
    checks++; if ({jtag_TDO_driven, jtag_TDO_data} !== 2'b11) begin errors++; $display("FAIL fall_lat_3rd got %b exp 11", {jtag_TDO_driven, jtag_TDO_data}); end
    @(negedge clk);
    jtag_TCK = 1'b1;
    changed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (jtag_TDO_data !== 1'b1) changed = 1'b1;
    end
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL tdo_moved_on_rise got %b exp 0", changed); end
    @(negedge clk);
    jtag_TCK = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (jtag_TDO_data !== 1'b0) begin errors++; $display("FAIL tdo_bit1 got %b exp 0", jtag_TDO_data); end
    @(negedge clk);
    tck_step(1'b1, 1'b0);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL timing_end_state got %h exp %h", tap_state, 4'hC); end
  endtask

  task automatic test_bypass();
    logic [4:0] irout;
    logic [63:0] dout;
    logic drv_all, drv_after;
    scan_ir(5'h1F, irout);
    checks++; if (irout !== 5'b00001) begin errors++; $display("FAIL bypass_ir_capture got %b exp 00001", irout); end
    scan_dr(64'hD, 4, dout, drv_all, drv_after);
    checks++; if (dout[3:0] !== 4'b1010) begin errors++; $display("FAIL bypass_tdo got %b exp 1010", dout[3:0]); end
    checks++; if (drv_all !== 1'b1) begin errors++; $display("FAIL bypass_drv got %b exp 1", drv_all); end
  endtask

  task automatic test_wrap();
    logic [4:0] irout;
    logic [63:0] dout;
    logic drv_all, drv_after;
    scan_ir(5'h01, irout);
    checks++; if (irout !== 5'b00001) begin errors++; $display("FAIL wrap_ir_capture got %b exp 00001", irout); end
    scan_dr(64'h5A, 40, dout, drv_all, drv_after);
    checks++; if (dout[31:0] !== 32'h1000_0001) begin errors++; $display("FAIL wrap_idcode got %h exp %h", dout[31:0], 32'h1000_0001); end
    checks++; if (dout[39:32] !== 8'h5A) begin errors++; $display("FAIL wrap_passthru got %h exp 5a", dout[39:32]); end
  endtask

  task automatic test_user();
    logic [4:0] irout;
    logic [63:0] dout;
    logic drv_all, drv_after;
    int base;
    scan_ir(5'h10, irout);
    checks++; if (irout !== 5'b00001) begin errors++; $display("FAIL user_ir_capture got %b exp 00001", irout); end
    user_capture_data = 32'hDEAD_BEEF;
    base = pulse_cnt;
    scan_dr(64'hA5A5_0F0F, 32, dout, drv_all, drv_after);
    checks++; if (dout[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL user_capture got %h exp deadbeef", dout[31:0]); end
    checks++; if (user_update_data !== 32'hA5A5_0F0F) begin errors++; $display("FAIL user_update got %h exp a5a50f0f", user_update_data); end
    checks++; if (pulse_cnt - base !== 1) begin errors++; $display("FAIL user_pulses got %0d exp 1", pulse_cnt - base); end
    checks++; if (user_update_valid !== 1'b0) begin errors++; $display("FAIL user_valid_idle got %b exp 0", user_update_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] dout;
    logic drv_all, drv_after;
    int base;
    base = pulse_cnt;
    user_capture_data = 32'h1234_5678;
    scan_dr(64'hCAFE_F00D, 32, dout, drv_all, drv_after);
    checks++; if (dout[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL b2b_cap1 got %h exp 12345678", dout[31:0]); end
    checks++; if (user_update_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_upd1 got %h exp cafef00d", user_update_data); end
    user_capture_data = 32'h0F0F_F0F0;
    scan_dr(64'h1357_9BDF, 32, dout, drv_all, drv_after);
    checks++; if (dout[31:0] !== 32'h0F0F_F0F0) begin errors++; $display("FAIL b2b_cap2 got %h exp 0f0ff0f0", dout[31:0]); end
    checks++; if (user_update_data !== 32'h1357_9BDF) begin errors++; $display("FAIL b2b_upd2 got %h exp 13579bdf", user_update_data); end
    checks++; if (pulse_cnt - base !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulse_cnt - base); end
  endtask

  task automatic test_pause_reset();
    logic [4:0] irout;
    logic [63:0] dout;
    logic drv_all, drv_after;
    int base;
    scan_ir(5'h1F, irout);
    base = pulse_cnt;
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b1);
    tck_step(1'b0, 1'b1);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    checks++; if (tap_state !== 4'h3) begin errors++; $display("FAIL pause_state got %h exp %h", tap_state, 4'h3); end
    for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0);
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL tms5_state got %h exp %h", tap_state, 4'hF); end
    checks++; if (pulse_cnt - base !== 0) begin errors++; $display("FAIL tms5_pulses got %0d exp 0", pulse_cnt - base); end
    tck_step(1'b0, 1'b0);
    scan_dr(64'h0, 32, dout, drv_all, drv_after);
    checks++; if (dout[31:0] !== 32'h1000_0001) begin errors++; $display("FAIL tlr_ir_idcode got %h exp %h", dout[31:0], 32'h1000_0001); end
  endtask

  task automatic test_reset_mid_shift();
    logic [4:0] irout;
    int base;
    do_reset();
    checks++; if (user_update_data !== 32'h0) begin errors++; $display("FAIL rst_clears_upd got %h exp 0", user_update_data); end
    goto_idle();
    scan_ir(5'h10, irout);
    user_capture_data = 32'h8765_4321;
    base = pulse_cnt;
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck_step(1'b0, 1'b1);
    checks++; if (jtag_TDO_driven !== 1'b1) begin errors++; $display("FAIL mid_shift_drv got %b exp 1", jtag_TDO_driven); end
    rst_n = 1'b0;
    #1;
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL mid_rst_state got %h exp %h", tap_state, 4'hF); end
    checks++; if ({jtag_TDO_driven, jtag_TDO_data} !== 2'b00) begin errors++; $display("FAIL mid_rst_tdo got %b exp 00", {jtag_TDO_driven, jtag_TDO_data}); end
    checks++; if (user_update_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", user_update_valid); end
    repeat (3) @(posedge clk);
    jtag_TCK = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tck_step(1'b1, 1'b1);
    tck_step(1'b1, 1'b1);
    tck_step(1'b0, 1'b0);
    checks++; if (user_update_data !== 32'h0) begin errors++; $display("FAIL mid_rst_upd got %h exp 0", user_update_data); end
    checks++; if (pulse_cnt - base !== 0) begin errors++; $display("FAIL mid_rst_pulses got %0d exp 0", pulse_cnt - base); end
    checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL mid_rst_idle got %h exp %h", tap_state, 4'hC); end
  endtask

  task automatic test_random_phase();
    logic [4:0] irout;
    logic [63:0] dout;
    logic drv_all, drv_after;
    int offset;
    half_clks = 3;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      offset = $urandom_range(1, 8);
      if (offset >= 5) offset = offset + 1;
      #(offset);
      goto_idle();
      scan_dr(64'h0, 32, dout, drv_all, drv_after);
      checks++; if (dout[31:0] !== 32'h1000_0001) begin errors++; $display("FAIL rp_idcode got %h exp %h", dout[31:0], 32'h1000_0001); end
      scan_ir(5'h10, irout);
      checks++; if (irout !== 5'b00001) begin errors++; $display("FAIL rp_ir got %b exp 00001", irout); end
      user_capture_data = 32'h0BAD_F00D;
      scan_dr(64'h600D_CAFE, 32, dout, drv_all, drv_after);
      checks++; if (dout[31:0] !== 32'h0BAD_F00D) begin errors++; $display("FAIL rp_user_cap got %h exp 0badf00d", dout[31:0]); end
      checks++; if (user_update_data !== 32'h600D_CAFE) begin errors++; $display("FAIL rp_user_upd got %h exp 600dcafe", user_update_data); end
      scan_ir(5'h1F, irout);
      scan_dr(64'h6, 4, dout, drv_all, drv_after);
      checks++; if (dout[3:0] !== 4'b1100) begin errors++; $display("FAIL rp_bypass got %b exp 1100", dout[3:0]); end
    end
    half_clks = 4;
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_tdo_timing();
    test_bypass();
    test_wrap();
    test_user();
    test_back_to_back();
    test_pause_reset();
    test_reset_mid_shift();
    test_random_phase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_responder.md
JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

Interface
REQ-001 Parameter IR_LEN, default 5: instruction register width.
REQ-002 Parameter IDCODE_VAL, default 32'h1000_0001: IDCODE register value; bit 0 SHALL be 1.
REQ-003 Parameter OP_IDCODE, default 5'h01: IDCODE opcode.
REQ-004 Parameter OP_USER, default 5'h10: user data register opcode.
REQ-005 Parameter OP_BYPASS, default 5'h1F: BYPASS opcode; all unlisted opcodes SHALL also select BYPASS.
REQ-006 Port clk  in  1: single system clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-008 Port jtag_TCK  in  1: JTAG clock, asynchronous to clk.
REQ-009 Port jtag_TMS  in  1: test mode select, asynchronous to clk.
REQ-010 Port jtag_TDI  in  1: test data in, asynchronous to clk.
REQ-011 Port jtag_TDO_data  out  1: test data out.
REQ-012 Port jtag_TDO_driven  out  1: high while TDO is valid.
REQ-013 Port user_capture_data  in  32: value loaded in Capture-DR when USER is selected.
REQ-014 Port user_update_data  out  32: last value latched in Update-DR when USER is selected.
REQ-015 Port user_update_valid  out  1: one-clk pulse when user_update_data changes.
REQ-016 Port tap_state  out  4: current TAP state encoding, for debug.

Function
REQ-017 TCK, TMS and TDI SHALL each pass through a 2-flop synchronizer; TCK rise/fall SHALL be detected from the synchronized value plus one delayed copy.
REQ-018 A TCK rise event SHALL occur in the 3rd clk after the input edge.
REQ-019 TCK high and low phases SHALL each be at least 3 clk periods; shorter phases are unsupported.
REQ-020 On each rise event, the block SHALL sample synchronized TMS/TDI and advance the standard 16-state IEEE 1149.1 TAP FSM.
REQ-021 FSM states: Test-Logic-Reset, Run-Test/Idle, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and for IR.
REQ-022 Five consecutive rise events with TMS=1 SHALL reach Test-Logic-Reset from any state.
REQ-023 In Test-Logic-Reset, IR SHALL equal OP_IDCODE.
REQ-024 Capture-IR SHALL load the IR shift register with {0..., 2'b01}.
REQ-025 Shift-IR/Shift-DR SHALL shift right, LSB first, with TDI entering the MSB.
REQ-026 Update-IR SHALL copy the IR shift register to IR.
REQ-027 Capture-DR SHALL load per IR: IDCODE -> IDCODE_VAL (32 bit); USER -> user_capture_data (32 bit); BYPASS -> 1'b0 (1 bit).
REQ-028 Update-DR with USER selected SHALL latch the 32-bit shift register into user_update_data and pulse user_update_valid for exactly one clk.
REQ-029 On each fall event, jtag_TDO_data SHALL take the active shift register bit 0, and jtag_TDO_driven SHALL be 1 iff state is Shift-IR or Shift-DR; otherwise both outputs SHALL be 0.
REQ-030 TDO SHALL therefore change only in the 3rd clk after a TCK falling input edge, never on a rise event.
REQ-031 If a rise and a fall event would fall in the same clk, this is impossible by REQ-019 and requires no handling.
REQ-032 A shift of more bits than the register length SHALL continue to pass TDI through the register (wrap via TDI), without error.

Reset
REQ-033 rst_n low SHALL asynchronously force: FSM to Test-Logic-Reset, IR to OP_IDCODE, all shift registers and synchronizers to 0, jtag_TDO_data=0, jtag_TDO_driven=0, user_update_data=0, user_update_valid=0, tap_state=Test-Logic-Reset.
REQ-034 Reset asserted mid-shift SHALL abandon the shift; no Update SHALL occur.
REQ-035 The first rise event SHALL be accepted no earlier than 3 clk after rst_n deassertion.

Structure
REQ-036 Package jtag_tap_pkg SHALL hold the TAP state enum (4-bit), default opcodes, and IDCODE default.
REQ-037 Sub-module jtag_tck_sync SHALL hold the synchronizers and the rise/fall edge detect; the FSM and registers SHALL be in jtag_tap_responder.

Verification
REQ-038 Reset, then 5 TMS=1 TCKs, TMS=0, go to Shift-DR, shift 32 bits -> TDO LSB-first equals 32'h1000_0001, jtag_TDO_driven=1 only in Shift-DR.
REQ-039 Load IR=5'h1F, shift DR with TDI=1,0,1,1 -> TDO returns 0,1,0,1 (one-bit delay).
REQ-040 Shift-IR with IR=5'h10 -> TDO returns 5'b00001 LSB-first; then with user_capture_data=32'hDEADBEEF, DR shift returns it; shifting in 32'hA5A5_0F0F gives user_update_data=32'hA5A5_0F0F and one user_update_valid pulse at Update-DR.
REQ-041 From Pause-DR, 5 TMS=1 TCKs -> Test-Logic-Reset, IR=OP_IDCODE, no user_update_valid pulse.
REQ-042 Assert rst_n low at bit 10 of a USER shift -> outputs at reset values immediately; user_update_data stays 0.
REQ-043 TCK half period = 3 clk, randomized phase -> all results match a 1149.1 reference model.
